// File: rtl/tx_sched_pkg.sv
// tx_sched_pkg: shared types and constants for the TX message scheduler.
// FSM state encoding, requester bit positions inside the 3-bit request and
// ack vectors, the default message length and the fixed-priority helper.
package tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GRANT     = 3'd1,
    S_STROBE    = 3'd2,
    S_SETTLE    = 3'd3,
    S_SEND      = 3'd4,
    S_WAIT_DONE = 3'd5,
    S_FINISH    = 3'd6,
    S_GAP       = 3'd7
  } state_t;

  // Requester bit positions in request, clear, grant and ack vectors.
  localparam int CTRL = 2;
  localparam int INIT = 1;
  localparam int NORM = 0;

  // Bytes per message, trailing line feed included.
  localparam int MSG_LEN_DEF = 35;

  // Fixed priority CONTROL > INITIAL > NORMAL, one-hot result.
  function automatic logic [2:0] prio_onehot(input logic [2:0] p);
    logic [2:0] g;
    g = 3'b000;
    if (p[CTRL])      g[CTRL] = 1'b1;
    else if (p[INIT]) g[INIT] = 1'b1;
    else if (p[NORM]) g[NORM] = 1'b1;
    return g;
  endfunction

endpackage

// File: rtl/tx_req_arbiter.sv
// tx_req_arbiter: sticky pending bits per requester plus fixed-priority grant.
// A request pulse sets its bit; a clear removes it. A request arriving in the
// same cycle as its own clear wins, so a request is never dropped.
module tx_req_arbiter
  import tx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_req,
  input  logic [2:0] i_clr,
  output logic [2:0] o_grant
);

  logic [2:0] r_pend;

  // Pending bits: merge repeated pulses, drop a bit only on its clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pend <= 3'b000;
    else        r_pend <= (r_pend & ~i_clr) | i_req;
  end

  assign o_grant = prio_onehot(r_pend);

endmodule

// File: rtl/tx_msg_sched.sv
// tx_msg_sched: picks one pending message request, walks the message memory
// byte by byte and hands each byte to the UART, then enforces an idle gap.
// Optional feature macro: TX_SCHED_TIMEOUT_EN (abort a byte wait after
// TIMEOUT_CYC cycles and flag it on oERR).
//
// Handshakes: iREQ_* are single-cycle pulses latched as pending until that
// requester's oACK bit pulses (one cycle, in FINISH). Each byte is a
// oUART_START pulse with oUART_DATA valid in the same cycle; the UART answers
// with one iUART_DONE pulse, which is only honoured in WAIT_DONE.
module tx_msg_sched
  import tx_sched_pkg::*;
#(
  parameter int MSG_LEN     = MSG_LEN_DEF,
  parameter int GAP_CYC     = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iREQ_CONTROL,
  input  logic       iREQ_INITIAL,
  input  logic       iREQ_NORMAL,
  input  logic [7:0] iRATE,
  input  logic [7:0] iTX_DATA_MEM,
  input  logic       iUART_DONE,
  output logic       oTX_START_CONTROL,
  output logic       oTX_INITIAL,
  output logic       oTX_NORMAL,
  output logic       oTX_RATE_STATE,
  output logic       oFINISH,
  output logic [7:0] oRATE,
  output logic       oUART_START,
  output logic [7:0] oUART_DATA,
  output logic [2:0] oACK,
  output logic       oBUSY,
  output logic       oERR,
  output logic [2:0] oDBG_STATE
);

  localparam logic [5:0]  CNT_LAST = 6'(MSG_LEN - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYC - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

  state_t      r_state;
  state_t      w_next;
  logic [2:0]  r_sel;
  logic [7:0]  r_rate;
  logic [7:0]  r_data;
  logic [5:0]  r_cnt;
  logic [15:0] r_gap;
  logic [2:0]  w_req;
  logic [2:0]  w_clr;
  logic [2:0]  w_grant;
  logic        w_timeout;

  assign w_req = {iREQ_CONTROL, iREQ_INITIAL, iREQ_NORMAL};
  // The served requester is released (and acked) in FINISH, timeout or not.
  assign w_clr = (r_state == S_FINISH) ? r_sel : 3'b000;

  tx_req_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .i_req   (w_req),
    .i_clr   (w_clr),
    .o_grant (w_grant)
  );

`ifdef TX_SCHED_TIMEOUT_EN
  logic [15:0] r_to;
  logic        r_to_hit;

  // Counts cycles since the current byte's start; 1 in the first WAIT_DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                        r_to <= 16'd0;
    else if (r_state == S_SEND)        r_to <= 16'd1;
    else if (r_state == S_WAIT_DONE)   r_to <= r_to + 16'd1;
    else                               r_to <= 16'd0;
  end

  // A done pulse in the expiry cycle still counts as a normal completion.
  assign w_timeout = (r_state == S_WAIT_DONE) && !iUART_DONE && (r_to == TO_LAST);

  // Remembers that the FINISH being entered is an abort.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_to_hit <= 1'b0;
    else        r_to_hit <= w_timeout;
  end

  assign oERR = (r_state == S_FINISH) && r_to_hit;
`else
  logic w_unused_to;
  assign w_timeout   = 1'b0;
  assign oERR        = 1'b0;
  assign w_unused_to = ^TO_LAST;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; arbitration is only looked at in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (|w_grant) w_next = S_GRANT;
      S_GRANT:     w_next = S_STROBE;
      S_STROBE:    w_next = S_SETTLE;
      S_SETTLE:    w_next = S_SEND;
      S_SEND:      w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (iUART_DONE)     w_next = (r_cnt == CNT_LAST) ? S_FINISH : S_STROBE;
        else if (w_timeout) w_next = S_FINISH;
      end
      S_FINISH:    w_next = (GAP_CYC == 0) ? S_IDLE : S_GAP;
      S_GAP:       if (r_gap == GAP_LAST) w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Datapath: select and rate captured on the grant edge, byte counter,
  // outgoing byte capture after the memory settle cycle, gap counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel  <= 3'b000;
      r_rate <= 8'h00;
      r_data <= 8'h00;
      r_cnt  <= 6'd0;
      r_gap  <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_next == S_GRANT) begin
            r_sel  <= w_grant;
            r_rate <= iRATE;
          end
        end
        S_GRANT:     r_cnt  <= 6'd0;
        S_SETTLE:    r_data <= iTX_DATA_MEM;
        S_WAIT_DONE: if (iUART_DONE) r_cnt <= r_cnt + 6'd1;
        S_FINISH: begin
          r_sel <= 3'b000;
          r_gap <= 16'd0;
        end
        S_GAP:       r_gap <= r_gap + 16'd1;
        default:     ;
      endcase
    end
  end

  assign oTX_START_CONTROL = r_sel[CTRL];
  assign oTX_INITIAL       = r_sel[INIT];
  assign oTX_NORMAL        = r_sel[NORM];
  assign oTX_RATE_STATE    = (r_state == S_STROBE);
  assign oUART_START       = (r_state == S_SEND);
  assign oFINISH           = (r_state == S_FINISH);
  assign oACK              = w_clr;
  assign oBUSY             = (r_state != S_IDLE);
  assign oRATE             = r_rate;
  assign oUART_DATA        = r_data;
  assign oDBG_STATE        = r_state;

endmodule
